spi_ss_onehot_gen: RTL and testbench

SPI_SS_ONEHOT_GEN -- requirements
Module: spi_ss_onehot_gen

---
 rtl/spi_ss_onehot_gen.sv | 158 +++++++++++++++
 tb/tb_spi_ss_onehot_gen.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/spi_ss_onehot_gen.sv
// One-hot SPI slave-select sequencer: IDLE -> SETUP -> ACTIVE -> HOLD -> GAP -> IDLE.
// All outputs are registered and decoded from the next state, so they track the state exactly.
module spi_ss_onehot_gen #(
    parameter int unsigned M         = 5,
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned HOLD_CYC  = 2,
    parameter int unsigned GAP_CYC   = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_req_valid,
    output logic         o_req_ready,
    input  logic [2:0]   i_req_idx,
    input  logic         i_xfer_done,
    output logic         o_start,
    output logic [M-1:0] o_ss_n,
    output logic [M-1:0] o_sel_onehot,
    output logic         o_busy,
    output logic         o_err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ACTIVE = 3'd2,
        HOLD   = 3'd3,
        GAP    = 3'd4
    } state_t;

    localparam logic [3:0] M_LIM    = 4'(M);
    localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
    localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYC - 1);
    localparam logic [3:0] GAP_LD   = (GAP_CYC > 0) ? 4'(GAP_CYC - 1) : 4'd0;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [3:0]   r_cnt;
    logic [3:0]   w_cnt_nxt;
    logic [2:0]   r_idx;
    logic [2:0]   w_idx_nxt;
    logic         w_hs;
    logic         w_idx_ok;
    logic         w_accept;
    logic         w_reject;
    logic         w_start;
    logic [M-1:0] w_sel;

    logic         r_req_ready;
    logic         r_start;
    logic [M-1:0] r_ss_n;
    logic [M-1:0] r_sel;
    logic         r_busy;
    logic         r_err;

    // r_req_ready is only ever set while the next state is IDLE, so it doubles as the IDLE qualifier
    assign w_hs     = i_req_valid && r_req_ready && (r_state == IDLE);
    assign w_idx_ok = ({1'b0, i_req_idx} < M_LIM);
    assign w_accept = w_hs && w_idx_ok;
    assign w_reject = w_hs && !w_idx_ok;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = SETUP;
                    w_cnt_nxt   = SETUP_LD;
                    w_idx_nxt   = i_req_idx;
                end
            end
            SETUP: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = ACTIVE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ACTIVE: begin
                if (i_xfer_done) begin
                    w_state_nxt = HOLD;
                    w_cnt_nxt   = HOLD_LD;
                end
            end
            HOLD: begin
                if (r_cnt == 4'd0) begin
                    if (GAP_CYC == 0) begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = GAP;
                        w_cnt_nxt   = GAP_LD;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            GAP: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        w_sel = '0;
        for (int unsigned i = 0; i < M; i++) begin
            if ((w_state_nxt == SETUP || w_state_nxt == ACTIVE || w_state_nxt == HOLD)
                && (3'(i) == w_idx_nxt)) begin
                w_sel[i] = 1'b1;
            end
        end
    end

    assign w_start = (w_state_nxt == ACTIVE) && (r_state != ACTIVE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_req_ready <= 1'b0;
            r_start     <= 1'b0;
            r_ss_n      <= '1;
            r_sel       <= '0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_req_ready <= (w_state_nxt == IDLE);
            r_start     <= w_start;
            r_ss_n      <= ~w_sel;
            r_sel       <= w_sel;
            r_busy      <= (w_state_nxt != IDLE);
            r_err       <= w_reject;
        end
    end

    assign o_req_ready  = r_req_ready;
    assign o_start      = r_start;
    assign o_ss_n       = r_ss_n;
    assign o_sel_onehot = r_sel;
    assign o_busy       = r_busy;
    assign o_err        = r_err;

endmodule

// File: tb/tb_spi_ss_onehot_gen.sv
// Directed table-driven bench for spi_ss_onehot_gen: defaults instance plus a GAP_CYC=0 instance.
module tb_spi_ss_onehot_gen;

    logic       clk;
    logic       rst_n;

    logic       v0, d0;
    logic [2:0] idx0;
    logic       rdy0, st0, bsy0, err0;
    logic [4:0] ss0, sel0;

    logic       v1, d1;
    logic [2:0] idx1;
    logic       rdy1, st1, bsy1, err1;
    logic [4:0] ss1, sel1;

    int errors = 0;
    int checks = 0;

    spi_ss_onehot_gen #(.M(5), .SETUP_CYC(2), .HOLD_CYC(2), .GAP_CYC(1)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(v0), .o_req_ready(rdy0),
        .i_req_idx(idx0), .i_xfer_done(d0), .o_start(st0), .o_ss_n(ss0),
        .o_sel_onehot(sel0), .o_busy(bsy0), .o_err(err0)
    );

    spi_ss_onehot_gen #(.M(5), .SETUP_CYC(2), .HOLD_CYC(2), .GAP_CYC(0)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(v1), .o_req_ready(rdy1),
        .i_req_idx(idx1), .i_xfer_done(d1), .o_start(st1), .o_ss_n(ss1),
        .o_sel_onehot(sel1), .o_busy(bsy1), .o_err(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         u;
        bit         v;
        logic [2:0] idx;
        bit         d;
        logic [4:0] ss;
        bit         st;
        bit         bsy;
        bit         er;
        bit         rdy;
    } vec_t;

    vec_t vq[$];

    task automatic add(input bit u, input bit v, input logic [2:0] idx, input bit d,
                       input logic [4:0] ss, input bit st, input bit bsy, input bit er, input bit rdy);
        vec_t r;
        r.u = u; r.v = v; r.idx = idx; r.d = d;
        r.ss = ss; r.st = st; r.bsy = bsy; r.er = er; r.rdy = rdy;
        vq.push_back(r);
    endtask

    task automatic chk(input string nm, input int row, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0h expected %0h (t=%0t)", nm, row, act, exp, $time);
        end
    endtask

    // At most one select may be active on either instance, every cycle out of reset
    always @(negedge clk) begin
        if (rst_n) begin
            chk("onehot0", -1, 8'($countones(sel0) <= 1), 8'd1);
            chk("onehot1", -1, 8'($countones(sel1) <= 1), 8'd1);
        end
    end

    initial begin
        logic [4:0] a_ss, a_sel, e_sel;
        logic       a_st, a_bsy, a_er, a_rdy;

        // idx=3 transaction, done driven during the 4th cycle after start
        for (int p = 0; p < 2; p++) begin
            bit dp;
            dp = (p == 1);
            add(0, 0, 3'd0, dp,   5'h1F, 0, 0, 0, 1);
            add(0, 1, 3'd3, dp,   5'h17, 0, 1, 0, 0);
            add(0, 0, 3'd0, dp,   5'h17, 0, 1, 0, 0);
            add(0, 0, 3'd0, dp,   5'h17, 1, 1, 0, 0);
            add(0, 1, 3'd1, 0,    5'h17, 0, 1, 0, 0);
            add(0, 0, 3'd0, 0,    5'h17, 0, 1, 0, 0);
            add(0, 0, 3'd0, 0,    5'h17, 0, 1, 0, 0);
            add(0, 0, 3'd0, 0,    5'h17, 0, 1, 0, 0);
            add(0, 0, 3'd0, 1,    5'h17, 0, 1, 0, 0);
            add(0, 0, 3'd0, dp,   5'h17, 0, 1, 0, 0);
            add(0, 0, 3'd0, dp,   5'h1F, 0, 1, 0, 0);
            add(0, 0, 3'd0, dp,   5'h1F, 0, 0, 0, 1);
        end
        // out-of-range indices
        add(0, 1, 3'd6, 0, 5'h1F, 0, 0, 1, 1);
        add(0, 0, 3'd0, 0, 5'h1F, 0, 0, 0, 1);
        add(0, 1, 3'd5, 0, 5'h1F, 0, 0, 1, 1);
        add(0, 0, 3'd0, 0, 5'h1F, 0, 0, 0, 1);
        // done coincident with start
        add(0, 1, 3'd0, 0, 5'h1E, 0, 1, 0, 0);
        add(0, 0, 3'd0, 0, 5'h1E, 0, 1, 0, 0);
        add(0, 0, 3'd0, 0, 5'h1E, 1, 1, 0, 0);
        add(0, 0, 3'd0, 1, 5'h1E, 0, 1, 0, 0);
        add(0, 0, 3'd0, 0, 5'h1E, 0, 1, 0, 0);
        add(0, 0, 3'd0, 0, 5'h1F, 0, 1, 0, 0);
        add(0, 0, 3'd0, 0, 5'h1F, 0, 0, 0, 1);
        // GAP_CYC=0 instance: idx 1 then idx 4 back to back, valid held
        add(1, 1, 3'd1, 0, 5'h1D, 0, 1, 0, 0);
        add(1, 1, 3'd4, 0, 5'h1D, 0, 1, 0, 0);
        add(1, 1, 3'd4, 0, 5'h1D, 1, 1, 0, 0);
        add(1, 1, 3'd4, 1, 5'h1D, 0, 1, 0, 0);
        add(1, 1, 3'd4, 0, 5'h1D, 0, 1, 0, 0);
        add(1, 1, 3'd4, 0, 5'h1F, 0, 0, 0, 1);
        add(1, 1, 3'd4, 0, 5'h0F, 0, 1, 0, 0);
        add(1, 0, 3'd0, 0, 5'h0F, 0, 1, 0, 0);
        add(1, 0, 3'd0, 0, 5'h0F, 1, 1, 0, 0);
        add(1, 0, 3'd0, 1, 5'h0F, 0, 1, 0, 0);
        add(1, 0, 3'd0, 0, 5'h0F, 0, 1, 0, 0);
        add(1, 0, 3'd0, 0, 5'h1F, 0, 0, 0, 1);

        rst_n = 1'b0;
        v0 = 0; d0 = 0; idx0 = '0;
        v1 = 0; d1 = 0; idx1 = '0;
        #12;
        chk("rst_ss",    -1, 8'(ss0),  8'h1F);
        chk("rst_sel",   -1, 8'(sel0), 8'h00);
        chk("rst_start", -1, 8'(st0),  8'h00);
        chk("rst_busy",  -1, 8'(bsy0), 8'h00);
        chk("rst_err",   -1, 8'(err0), 8'h00);
        chk("rst_ready", -1, 8'(rdy0), 8'h00);
        chk("rst_ready1", -1, 8'(rdy1), 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vq[i]) begin
            if (vq[i].u) begin
                v1 = vq[i].v; idx1 = vq[i].idx; d1 = vq[i].d;
                v0 = 0; idx0 = '0; d0 = 0;
            end else begin
                v0 = vq[i].v; idx0 = vq[i].idx; d0 = vq[i].d;
                v1 = 0; idx1 = '0; d1 = 0;
            end
            @(posedge clk);
            #1;
            if (vq[i].u) begin
                a_ss = ss1; a_sel = sel1; a_st = st1; a_bsy = bsy1; a_er = err1; a_rdy = rdy1;
            end else begin
                a_ss = ss0; a_sel = sel0; a_st = st0; a_bsy = bsy0; a_er = err0; a_rdy = rdy0;
            end
            e_sel = ~vq[i].ss;
            chk("ss_n",  i, 8'(a_ss),  8'(vq[i].ss));
            chk("sel",   i, 8'(a_sel), 8'(e_sel));
            chk("start", i, 8'(a_st),  8'(vq[i].st));
            chk("busy",  i, 8'(a_bsy), 8'(vq[i].bsy));
            chk("err",   i, 8'(a_er),  8'(vq[i].er));
            chk("ready", i, 8'(a_rdy), 8'(vq[i].rdy));
        end
        v0 = 0; v1 = 0; d0 = 0; d1 = 0;

        // reset asserted mid-ACTIVE with idx=0
        v0 = 1; idx0 = 3'd0;
        @(posedge clk); #1;
        v0 = 0;
        chk("arst_setup", -1, 8'(ss0), 8'h1E);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("arst_start", -1, 8'(st0), 8'h01);
        @(posedge clk); #1;
        chk("arst_active", -1, 8'(ss0), 8'h1E);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ss",    -1, 8'(ss0),  8'h1F);
        chk("arst_sel",   -1, 8'(sel0), 8'h00);
        chk("arst_busy",  -1, 8'(bsy0), 8'h00);
        chk("arst_start0", -1, 8'(st0), 8'h00);
        chk("arst_err",   -1, 8'(err0), 8'h00);
        chk("arst_ready", -1, 8'(rdy0), 8'h00);
        @(posedge clk); #1;
        chk("arst_hold_ss",   -1, 8'(ss0),  8'h1F);
        chk("arst_hold_rdy",  -1, 8'(rdy0), 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_ready", -1, 8'(rdy0), 8'h01);
        chk("rel_busy",  -1, 8'(bsy0), 8'h00);
        chk("rel_ss",    -1, 8'(ss0),  8'h1F);
        chk("rel_start", -1, 8'(st0),  8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
